frog_hop_ctrl: RTL
==================

Name: frog_hop_ctrl

Overview:
Player movement controller for the Frogger game. Converts keyboard keycodes into discrete, tile-aligned hops and sequences the frog position register on the frame clock. Handles bounds rejection, post-hop cooldown, death and respawn. FrogX/FrogY feed the sprite/draw logic; the hit input comes from the hazard collision logic.

Parameters:
X_START, 320, respawn X (tile top-left, pixels)
Y_START, 448, respawn Y
X_MIN, 0, leftmost legal X
X_MAX, 608, rightmost legal X
Y_MIN, 0, topmost legal Y
Y_MAX, 448, bottommost legal Y
STEP, 4, pixels moved per frame during a hop
HOP_FRAMES, 8, frames per hop; tile size = STEP*HOP_FRAMES = 32
COOL_FRAMES, 2, idle frames after a hop before next press is accepted (0 allowed)
DEATH_FRAMES, 60, frames spent in DEAD before respawn

Ports:
frame_clk  in   1   frame clock (~60 Hz), sole clock
Reset_n    in   1   synchronous reset, active-low
keycode    in   16  USB keycode: 0x001A up, 0x0004 left, 0x0007 right, 0x0016 down; others = no key
hit        in   1   collision with hazard, sampled each frame
FrogX      out  10  frog X position
FrogY      out  10  frog Y position
Dir        out  2   facing: 00 up, 01 left, 10 right, 11 down
Hopping    out  1   high while state == HOP
Dead       out  1   high while state == DEAD
Hops       out  8   completed forward (up) hops since spawn, saturating at 255
LEDG       out  9   [0] IDLE, [1] HOP, [2] COOL, [3] DEAD one-hot; [8:4] = 0

Behaviour:
- One clock, frame_clk. Reset is synchronous, active-low (Reset_n); it overrides all other activity, including mid-hop/mid-death.
- Reset values: FrogX=X_START, FrogY=Y_START, Dir=00, Hopping=0, Dead=0, Hops=0, state=IDLE, counter=0, key_prev=0.
- Press detect: key_prev <= keycode every cycle (all states). new_press = keycode is one of the 4 codes AND keycode != key_prev. A held key yields exactly one press.
- TILE = STEP*HOP_FRAMES. Bounds check before arithmetic (no unsigned underflow): up legal iff FrogY >= Y_MIN+TILE; down iff FrogY+TILE <= Y_MAX; left iff FrogX >= X_MIN+TILE; right iff FrogX+TILE <= X_MAX.
- IDLE: hit -> DEAD (hit has priority over press). Else new_press: Dir <= pressed direction; if legal -> HOP, counter=0; if illegal -> stay IDLE, position unchanged (frog turns only).
- HOP: each cycle position += / -= STEP along Dir, counter++. On the cycle applying the HOP_FRAMES-th step -> COOL (or IDLE if COOL_FRAMES=0), counter=0; if Dir=up, Hops++ (saturating). Latency: press sampled at edge k enters HOP; position changes at edges k+1..k+HOP_FRAMES; lands exactly one TILE away.
- COOL: counts COOL_FRAMES cycles then IDLE. Presses ignored.
- hit in HOP or COOL -> DEAD at that edge; position frozen at current (possibly mid-tile) value; the step for that cycle is not applied.
- DEAD: Dead=1; keycode and hit ignored; after DEATH_FRAMES cycles -> IDLE with FrogX=X_START, FrogY=Y_START, Dir=00, Hops=0.
- Simultaneous hit and press in IDLE: hit wins, no Dir update.
- All arithmetic 10-bit unsigned; bounds guarantee no wrap.

Optional Feature:
HOP_QUEUE_EN. Defined: one-entry direction buffer; a new_press during HOP or COOL stores its direction (latest overwrites, valid bit set). In the first IDLE cycle the queued entry is consumed as if it were a new_press (bounds checked then; live new_press in that cycle takes precedence and clears the queue). Queue cleared on entry to DEAD and on reset. Not defined: presses during HOP/COOL are dropped; key_prev still tracks, so a key held across the hop does not retrigger.

Test Plan:
- Reset, keycode 0x001A for 1 frame then 0 -> Hopping high 8 frames, FrogY 448->444->...->416, Hops=1, 2 COOL frames, back to IDLE.
- Hold 0x0007 for 40 frames -> exactly one hop, FrogX 320->352, stays 352.
- Move to FrogX=608, press 0x0007 -> no motion, Dir=10, LEDG[0]=1; at FrogY=448 press 0x0016 -> no motion, Dir=11.
- Press up, assert hit after 3 steps -> Dead=1, FrogY frozen at 436; 60 frames later FrogX/FrogY=320/448, Hops=0, Dir=00.
- Drive Reset_n=0 mid-hop for one edge -> next edge all outputs at reset values, state IDLE.
- Press up, then 0x0004 during HOP -> without HOP_QUEUE_EN FrogX stays 320; with it, left hop starts in first IDLE frame after COOL, FrogX ends 288.

Source files
------------

// File: rtl/frog_hop_ctrl.sv
// frog_hop_ctrl: keyboard-driven, tile-aligned frog movement controller.
// Converts keycode edges into hops of STEP pixels per frame for HOP_FRAMES
// frames, with bounds rejection, post-hop cooldown, death and respawn.
// Optional feature macro: HOP_QUEUE_EN (one-entry buffer for a direction
// pressed during HOP/COOL, consumed in the first IDLE frame).
module frog_hop_ctrl #(
  parameter int unsigned X_START      = 320,
  parameter int unsigned Y_START      = 448,
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 608,
  parameter int unsigned Y_MIN        = 0,
  parameter int unsigned Y_MAX        = 448,
  parameter int unsigned STEP         = 4,
  parameter int unsigned HOP_FRAMES   = 8,
  parameter int unsigned COOL_FRAMES  = 2,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [15:0] keycode,
  input  logic        hit,
  output logic [9:0]  FrogX,
  output logic [9:0]  FrogY,
  output logic [1:0]  Dir,
  output logic        Hopping,
  output logic        Dead,
  output logic [7:0]  Hops,
  output logic [8:0]  LEDG
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOP  = 2'd1,
    S_COOL = 2'd2,
    S_DEAD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  localparam int unsigned TILE      = STEP * HOP_FRAMES;
  localparam logic [15:0] HOP_LAST  = 16'(HOP_FRAMES - 1);
  localparam logic [15:0] COOL_LAST = 16'(COOL_FRAMES - 1);
  localparam logic [15:0] DEAD_LAST = 16'(DEATH_FRAMES - 1);
  localparam logic [9:0]  STEP_W    = 10'(STEP);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  dir_t        dir_q, dir_d;
  logic [7:0]  hops_q, hops_d;
  logic [15:0] key_prev_q;

`ifdef HOP_QUEUE_EN
  logic        qv_q, qv_d;
  dir_t        qdir_q, qdir_d;
`endif

  logic        key_is_move;
  dir_t        key_dir;
  logic        new_press;
  logic        take;
  dir_t        take_dir;

  // Bounds are evaluated in 11 bits so the tile offset cannot wrap or underflow.
  function automatic logic dir_legal(input dir_t d, input logic [9:0] x,
                                     input logic [9:0] y);
    logic ok;
    case (d)
      DIR_UP:    ok = ({1'b0, y} >= 11'(Y_MIN + TILE));
      DIR_DOWN:  ok = (({1'b0, y} + 11'(TILE)) <= 11'(Y_MAX));
      DIR_LEFT:  ok = ({1'b0, x} >= 11'(X_MIN + TILE));
      DIR_RIGHT: ok = (({1'b0, x} + 11'(TILE)) <= 11'(X_MAX));
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Decode movement keycodes and detect a fresh press against last frame's key.
  always_comb begin
    key_is_move = 1'b1;
    key_dir     = DIR_UP;
    case (keycode)
      16'h001A: key_dir = DIR_UP;
      16'h0004: key_dir = DIR_LEFT;
      16'h0007: key_dir = DIR_RIGHT;
      16'h0016: key_dir = DIR_DOWN;
      default:  key_is_move = 1'b0;
    endcase
    new_press = key_is_move && (keycode != key_prev_q);
  end

  // Select the direction request honoured in IDLE: live press first, then queue.
  always_comb begin
    take     = new_press;
    take_dir = key_dir;
`ifdef HOP_QUEUE_EN
    if (!new_press && qv_q) begin
      take     = 1'b1;
      take_dir = qdir_q;
    end
`endif
  end

  // Next-state, position, direction and hop-count logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    hops_d  = hops_q;
`ifdef HOP_QUEUE_EN
    qv_d    = qv_q;
    qdir_d  = qdir_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef HOP_QUEUE_EN
        qv_d = 1'b0;
`endif
        if (hit) begin
          state_d = S_DEAD;
          cnt_d   = '0;
        end else if (take) begin
          dir_d = take_dir;
          if (dir_legal(take_dir, x_q, y_q)) begin
            state_d = S_HOP;
            cnt_d   = '0;
          end
        end
      end

      S_HOP: begin
        if (hit) begin
          state_d = S_DEAD;
          cnt_d   = '0;
`ifdef HOP_QUEUE_EN
          qv_d    = 1'b0;
`endif
        end else begin
          case (dir_q)
            DIR_UP:    y_d = y_q - STEP_W;
            DIR_DOWN:  y_d = y_q + STEP_W;
            DIR_LEFT:  x_d = x_q - STEP_W;
            DIR_RIGHT: x_d = x_q + STEP_W;
            default:   ;
          endcase
          if (cnt_q == HOP_LAST) begin
            cnt_d   = '0;
            state_d = (COOL_FRAMES == 0) ? S_IDLE : S_COOL;
            if (dir_q == DIR_UP && hops_q != '1) begin
              hops_d = hops_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
`ifdef HOP_QUEUE_EN
          if (new_press) begin
            qv_d   = 1'b1;
            qdir_d = key_dir;
          end
`endif
        end
      end

      S_COOL: begin
        if (hit) begin
          state_d = S_DEAD;
          cnt_d   = '0;
`ifdef HOP_QUEUE_EN
          qv_d    = 1'b0;
`endif
        end else begin
          if (cnt_q == COOL_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
`ifdef HOP_QUEUE_EN
          if (new_press) begin
            qv_d   = 1'b1;
            qdir_d = key_dir;
          end
`endif
        end
      end

      S_DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          x_d     = 10'(X_START);
          y_d     = 10'(Y_START);
          dir_d   = DIR_UP;
          hops_d  = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      x_q        <= 10'(X_START);
      y_q        <= 10'(Y_START);
      dir_q      <= DIR_UP;
      hops_q     <= '0;
      key_prev_q <= '0;
`ifdef HOP_QUEUE_EN
      qv_q       <= 1'b0;
      qdir_q     <= DIR_UP;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      hops_q     <= hops_d;
      key_prev_q <= keycode;
`ifdef HOP_QUEUE_EN
      qv_q       <= qv_d;
      qdir_q     <= qdir_d;
`endif
    end
  end

  assign FrogX   = x_q;
  assign FrogY   = y_q;
  assign Dir     = dir_q;
  assign Hops    = hops_q;
  assign Hopping = (state_q == S_HOP);
  assign Dead    = (state_q == S_DEAD);
  assign LEDG    = {5'b0, state_q == S_DEAD, state_q == S_COOL,
                    state_q == S_HOP, state_q == S_IDLE};

endmodule
